axi4_manager: RTL and testbench

Single-outstanding AXI4 manager (initiator) that turns a simple request/response port into single-beat AXI4 write (AW/W/B) and read (AR/R) transactions. It is the counterpart of the memory-backed subordinate on `axi4_if` and connects a core-side client (test driver, DMA, CPU stub) to that subordinate. At most one transaction is in flight; bursts and IDs are not supported.

---
 rtl/axi4_manager_pkg.sv | 37 +++
 rtl/axi4_manager_if.sv | 69 ++++++
 rtl/axi4_manager_valid_slot.sv | 46 ++++
 rtl/axi4_manager.sv | 140 ++++++++++++++
 tb/tb_axi4_manager.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/axi4_manager_pkg.sv
// =============================================================================
// hook : shared AXI4 response/burst encodings and manager FSM states
// Revision : 1.0
// =============================================================================
`default_nettype none

package hook;

   typedef enum logic [1:0] {
      RESP_OKAY   = 2'b00,
      RESP_EXOKAY = 2'b01,
      RESP_SLVERR = 2'b10,
      RESP_DECERR = 2'b11
   } axi_resp_e;

   typedef enum logic [1:0] {
      BURST_FIXED = 2'b00,
      BURST_INCR  = 2'b01,
      BURST_WRAP  = 2'b10
   } axi_burst_e;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_WR_REQ  = 3'd1,
      ST_WR_RESP = 3'd2,
      ST_RD_REQ  = 3'd3,
      ST_RD_RESP = 3'd4
   } mgr_state_e;

   // AxSIZE for a full-width beat: log2 of the byte count.
   function automatic logic [2:0] axi_size(input int data_w);
      return 3'($clog2(data_w / 8));
   endfunction

endpackage

`default_nettype wire

// File: rtl/axi4_manager_if.sv
// =============================================================================
// axi4_manager_if : client request/response port plus single-beat AXI4 channels
// Revision : 1.0
// =============================================================================
`default_nettype none

interface axi4_manager_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) ();

   logic                  req_valid;
   logic                  req_ready;
   logic                  req_we;
   logic [ADDR_W-1:0]     req_addr;
   logic [DATA_W-1:0]     req_wdata;
   logic                  rsp_valid;
   logic [DATA_W-1:0]     rsp_rdata;
   logic                  rsp_err;

   logic                  AWVALID;
   logic                  AWREADY;
   logic [ADDR_W-1:0]     AWADDR;
   logic [7:0]            AWLEN;
   logic [2:0]            AWSIZE;
   logic [1:0]            AWBURST;
   logic                  WVALID;
   logic                  WREADY;
   logic [DATA_W-1:0]     WDATA;
   logic [DATA_W/8-1:0]   WSTRB;
   logic                  WLAST;
   logic                  BVALID;
   logic                  BREADY;
   logic [1:0]            BRESP;
   logic                  ARVALID;
   logic                  ARREADY;
   logic [ADDR_W-1:0]     ARADDR;
   logic [7:0]            ARLEN;
   logic [2:0]            ARSIZE;
   logic [1:0]            ARBURST;
   logic                  RVALID;
   logic                  RREADY;
   logic [DATA_W-1:0]     RDATA;
   logic [1:0]            RRESP;
   logic                  RLAST;

   modport master (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err,
      output AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, input AWREADY,
      output WVALID, WDATA, WSTRB, WLAST, input WREADY,
      input  BVALID, BRESP, output BREADY,
      output ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, input ARREADY,
      input  RVALID, RDATA, RRESP, RLAST, output RREADY
   );

   modport slave (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err,
      input  AWVALID, AWADDR, AWLEN, AWSIZE, AWBURST, output AWREADY,
      input  WVALID, WDATA, WSTRB, WLAST, output WREADY,
      output BVALID, BRESP, input BREADY,
      input  ARVALID, ARADDR, ARLEN, ARSIZE, ARBURST, output ARREADY,
      output RVALID, RDATA, RRESP, RLAST, input RREADY
   );

endinterface

`default_nettype wire

// File: rtl/axi4_manager_valid_slot.sv
// =============================================================================
// axi_valid_slot : registered VALID + payload held until READY, with done flag
// Revision : 1.0
// =============================================================================
`default_nettype none

module axi_valid_slot #(
   parameter int WIDTH = 32
) (
   input  wire logic             clk,
   input  wire logic             rst,
   input  wire logic             load_i,
   input  wire logic [WIDTH-1:0] data_i,
   input  wire logic             ready_i,
   output logic                  valid_o,
   output logic [WIDTH-1:0]      data_o,
   output logic                  done_o
);

   logic             valid_q;
   logic             done_q;
   logic [WIDTH-1:0] data_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= 1'b0;
         done_q  <= 1'b0;
         data_q  <= '0;
      end else if (load_i) begin
         valid_q <= 1'b1;
         done_q  <= 1'b0;
         data_q  <= data_i;
      end else if (valid_q && ready_i) begin
         valid_q <= 1'b0;
         done_q  <= 1'b1;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   // Includes the handshake in progress so the FSM can advance on that same edge.
   assign done_o  = done_q || (valid_q && ready_i);

endmodule

`default_nettype wire

// File: rtl/axi4_manager.sv
// =============================================================================
// axi4_manager : single-outstanding AXI4 manager, req/rsp port to AW/W/B/AR/R
// Revision : 1.0
// =============================================================================
`default_nettype none

module axi4_manager
   import hook::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 32
) (
   input  wire logic        ACLK,
   input  wire logic        ARESET,
   axi4_manager_if.master   bus
);

   localparam logic [2:0] C_SIZE = axi_size(DATA_W);

   mgr_state_e        state_q;
   logic              bready_q;
   logic              rready_q;
   logic              rsp_valid_q;
   logic              rsp_err_q;
   logic [DATA_W-1:0] rsp_rdata_q;

   logic w_req_ready;
   logic w_accept;
   logic w_aw_done;
   logic w_w_done;
   logic w_ar_done;
   logic w_unused;

   assign w_req_ready = (state_q == ST_IDLE) && !ARESET;
   assign w_accept    = bus.req_valid && w_req_ready;

   axi_valid_slot #(.WIDTH(ADDR_W)) u_aw_slot (
      .clk     (ACLK),
      .rst     (ARESET),
      .load_i  (w_accept && bus.req_we),
      .data_i  (bus.req_addr),
      .ready_i (bus.AWREADY),
      .valid_o (bus.AWVALID),
      .data_o  (bus.AWADDR),
      .done_o  (w_aw_done)
   );

   axi_valid_slot #(.WIDTH(DATA_W)) u_w_slot (
      .clk     (ACLK),
      .rst     (ARESET),
      .load_i  (w_accept && bus.req_we),
      .data_i  (bus.req_wdata),
      .ready_i (bus.WREADY),
      .valid_o (bus.WVALID),
      .data_o  (bus.WDATA),
      .done_o  (w_w_done)
   );

   axi_valid_slot #(.WIDTH(ADDR_W)) u_ar_slot (
      .clk     (ACLK),
      .rst     (ARESET),
      .load_i  (w_accept && !bus.req_we),
      .data_i  (bus.req_addr),
      .ready_i (bus.ARREADY),
      .valid_o (bus.ARVALID),
      .data_o  (bus.ARADDR),
      .done_o  (w_ar_done)
   );

   always_ff @(posedge ACLK) begin
      if (ARESET) begin
         state_q     <= ST_IDLE;
         bready_q    <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_err_q   <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         rsp_valid_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (w_accept) state_q <= bus.req_we ? ST_WR_REQ : ST_RD_REQ;
            end
            ST_WR_REQ: begin
               if (w_aw_done && w_w_done) begin
                  state_q  <= ST_WR_RESP;
                  bready_q <= 1'b1;
               end
            end
            ST_WR_RESP: begin
               if (bus.BVALID) begin
                  state_q     <= ST_IDLE;
                  bready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= bus.BRESP[1];
                  rsp_rdata_q <= '0;
               end
            end
            ST_RD_REQ: begin
               if (w_ar_done) begin
                  state_q  <= ST_RD_RESP;
                  rready_q <= 1'b1;
               end
            end
            ST_RD_RESP: begin
               if (bus.RVALID) begin
                  state_q     <= ST_IDLE;
                  rready_q    <= 1'b0;
                  rsp_valid_q <= 1'b1;
                  rsp_err_q   <= bus.RRESP[1];
                  rsp_rdata_q <= bus.RDATA;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign bus.req_ready = w_req_ready;
   assign bus.rsp_valid = rsp_valid_q;
   assign bus.rsp_rdata = rsp_rdata_q;
   assign bus.rsp_err   = rsp_err_q;
   assign bus.BREADY    = bready_q;
   assign bus.RREADY    = rready_q;

   assign bus.AWLEN   = 8'd0;
   assign bus.AWSIZE  = C_SIZE;
   assign bus.AWBURST = BURST_INCR;
   assign bus.ARLEN   = 8'd0;
   assign bus.ARSIZE  = C_SIZE;
   assign bus.ARBURST = BURST_INCR;
   assign bus.WSTRB   = '1;
   assign bus.WLAST   = 1'b1;

   // Only the error bit of a response matters; RLAST is meaningless for single beats.
   assign w_unused = ^{bus.RLAST, bus.BRESP[0], bus.RRESP[0]};

endmodule

`default_nettype wire

// File: tb/tb_axi4_manager.sv
// =============================================================================
// tb_axi4_manager : randomized client + memory subordinate with reference model
// Revision : 1.0
// =============================================================================
`default_nettype none

module tb_axi4_manager;
   import hook::*;

   localparam int DATA_W = 32;
   localparam int ADDR_W = 32;

   logic ACLK   = 1'b0;
   logic ARESET = 1'b1;
   always #5 ACLK = ~ACLK;

   axi4_manager_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

   axi4_manager #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
      .ACLK   (ACLK),
      .ARESET (ARESET),
      .bus    (bus)
   );

   int n_vec = 0;
   int n_err = 0;
   logic [31:0] mem [logic [31:0]];

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_idle_bus(input string tag);
      check_eq({tag, "_awvalid"}, bus.AWVALID, 0);
      check_eq({tag, "_wvalid"},  bus.WVALID,  0);
      check_eq({tag, "_arvalid"}, bus.ARVALID, 0);
      check_eq({tag, "_bready"},  bus.BREADY,  0);
      check_eq({tag, "_rready"},  bus.RREADY,  0);
      check_eq({tag, "_rsp_valid"}, bus.rsp_valid, 0);
   endtask

   // Called at a negedge with the manager idle; returns at the negedge of the
   // rsp_valid cycle (or after the reset sequence when abort is set).
   task automatic run_txn(input bit we, input logic [31:0] addr, input logic [31:0] data,
                          input int aw_dly, input int w_dly, input int r_dly,
                          input logic [1:0] resp, input bit hold, input bit abort);
      bit aw_ok = 0, w_ok = 0, ar_ok = 0, rsp_ok = 0, phase;
      bit hs_aw, hs_w, hs_ar, hs_rsp;
      int rwait = 0, lat = 0;
      logic [31:0] exp_rd;
      exp_rd = mem.exists(addr) ? mem[addr] : 32'h0;

      bus.req_valid = 1'b1;
      bus.req_we    = we;
      bus.req_addr  = addr;
      bus.req_wdata = data;
      #1;
      check_eq("req_ready_idle", bus.req_ready, 1);
      @(posedge ACLK);
      #1;
      if (!hold) begin
         bus.req_valid = 1'b0;
         bus.req_addr  = $urandom;
         bus.req_wdata = $urandom;
      end

      for (int cyc = 1; cyc <= 300 && !rsp_ok; cyc++) begin
         @(negedge ACLK);
         phase       = we ? (aw_ok && w_ok) : ar_ok;
         bus.AWREADY = we && (cyc - 1 >= aw_dly);
         bus.WREADY  = we && (cyc - 1 >= w_dly);
         bus.ARREADY = !we && (cyc - 1 >= aw_dly);
         bus.BVALID  = we ? (phase && rwait >= r_dly) : 1'($urandom_range(0, 1));
         bus.RVALID  = !we ? (phase && rwait >= r_dly) : 1'($urandom_range(0, 1));
         bus.BRESP   = resp;
         bus.RRESP   = resp;
         bus.RLAST   = 1'b1;
         bus.RDATA   = (!we && phase) ? exp_rd : $urandom;

         check_eq("awvalid", bus.AWVALID, we && !aw_ok);
         check_eq("wvalid",  bus.WVALID,  we && !w_ok);
         check_eq("arvalid", bus.ARVALID, !we && !ar_ok);
         check_eq("bready",  bus.BREADY,  we && phase);
         check_eq("rready",  bus.RREADY,  !we && phase);
         check_eq("rsp_valid_busy", bus.rsp_valid, 0);
         check_eq("req_ready_busy", bus.req_ready, 0);
         if (we && !aw_ok) check_eq("awaddr", bus.AWADDR, addr);
         if (we && !w_ok) begin
            check_eq("wdata", bus.WDATA, data);
            check_eq("wstrb", bus.WSTRB, 4'hF);
            check_eq("wlast", bus.WLAST, 1);
         end
         if (!we && !ar_ok) check_eq("araddr", bus.ARADDR, addr);

         if (abort && phase && rwait == 1) begin
            bus.req_valid = 1'b0;
            ARESET = 1'b1;
            @(posedge ACLK);
            @(negedge ACLK);
            check_idle_bus("abort");
            check_eq("abort_req_ready", bus.req_ready, 0);
            ARESET = 1'b0;
            bus.BVALID = 1'b0;
            bus.RVALID = 1'b0;
            #1;
            check_eq("post_reset_req_ready", bus.req_ready, 1);
            @(negedge ACLK);
            check_idle_bus("post_abort");
            check_eq("post_abort_req_ready", bus.req_ready, 1);
            return;
         end

         hs_aw  = bus.AWVALID && bus.AWREADY;
         hs_w   = bus.WVALID && bus.WREADY;
         hs_ar  = bus.ARVALID && bus.ARREADY;
         hs_rsp = we ? (bus.BVALID && bus.BREADY) : (bus.RVALID && bus.RREADY);
         @(posedge ACLK);
         if (hs_aw) aw_ok = 1;
         if (hs_w)  w_ok  = 1;
         if (hs_ar) ar_ok = 1;
         if (phase) rwait++;
         if (hs_rsp) begin
            rsp_ok = 1;
            lat    = cyc + 1;
         end
      end

      check_eq("rsp_timeout", rsp_ok, 1);
      @(negedge ACLK);
      check_eq("rsp_valid",  bus.rsp_valid, 1);
      check_eq("rsp_rdata",  bus.rsp_rdata, we ? 32'h0 : exp_rd);
      check_eq("rsp_err",    bus.rsp_err, resp[1]);
      check_eq("req_ready_at_rsp", bus.req_ready, 1);
      if (aw_dly == 0 && w_dly == 0 && r_dly == 0) check_eq("latency", lat, 3);
      if (we && !resp[1]) mem[addr] = data;
   endtask

   bit          r_we, r_hold;
   logic [31:0] r_addr, r_data;
   logic [1:0]  r_resp;

   initial begin
      bus.req_valid = 1'b0;
      bus.req_we    = 1'b0;
      bus.req_addr  = '0;
      bus.req_wdata = '0;
      bus.AWREADY   = 1'b0;
      bus.WREADY    = 1'b0;
      bus.ARREADY   = 1'b0;
      bus.BVALID    = 1'b0;
      bus.BRESP     = 2'b00;
      bus.RVALID    = 1'b0;
      bus.RDATA     = '0;
      bus.RRESP     = 2'b00;
      bus.RLAST     = 1'b1;

      repeat (3) @(posedge ACLK);
      @(negedge ACLK);
      check_idle_bus("reset");
      check_eq("reset_req_ready", bus.req_ready, 0);
      check_eq("reset_rsp_rdata", bus.rsp_rdata, 0);
      check_eq("reset_rsp_err",   bus.rsp_err, 0);
      check_eq("reset_awaddr",    bus.AWADDR, 0);
      check_eq("reset_wdata",     bus.WDATA, 0);
      check_eq("awlen",   bus.AWLEN, 0);
      check_eq("awsize",  bus.AWSIZE, 2);
      check_eq("awburst", bus.AWBURST, 1);
      check_eq("arlen",   bus.ARLEN, 0);
      check_eq("arsize",  bus.ARSIZE, 2);
      check_eq("arburst", bus.ARBURST, 1);
      ARESET = 1'b0;

      run_txn(1, 32'h40,  32'hDEAD_BEEF, 0, 0, 0, RESP_OKAY,   0, 0);
      run_txn(1, 32'h44,  32'hCAFE_F00D, 0, 4, 0, RESP_OKAY,   0, 0);
      run_txn(1, 32'h80,  32'h1234_5678, 0, 0, 0, RESP_EXOKAY, 0, 0);
      run_txn(0, 32'h80,  32'h0,         0, 0, 2, RESP_SLVERR, 1, 0);
      run_txn(0, 32'h40,  32'h0,         0, 0, 0, RESP_OKAY,   0, 0);
      run_txn(1, 32'h100, 32'hA5A5_5A5A, 0, 0, 10, RESP_OKAY,  0, 1);
      run_txn(1, 32'h104, 32'h0BAD_F00D, 0, 0, 0, RESP_OKAY,   0, 0);
      run_txn(0, 32'h104, 32'h0,         0, 0, 0, RESP_OKAY,   0, 0);
      run_txn(0, 32'h100, 32'h0,         1, 0, 1, RESP_DECERR, 0, 0);

      for (int i = 0; i < 40; i++) begin
         r_we   = 1'($urandom_range(0, 1));
         r_hold = 1'($urandom_range(0, 1));
         r_addr = 32'($urandom_range(0, 15)) * 32'd4;
         r_data = $urandom;
         r_resp = 2'($urandom_range(0, 3));
         run_txn(r_we, r_addr, r_data, $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 3), r_resp, r_hold, 0);
      end

      bus.req_valid = 1'b0;
      @(negedge ACLK);
      check_eq("final_rsp_valid", bus.rsp_valid, 0);
      check_eq("final_req_ready", bus.req_ready, 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire
